pbkdf2_f_sha256: RTL and testbench



---
 rtl/pbkdf2_f_sha256.sv | 262 ++++++++++++++++++++++++++
 tb/tb_pbkdf2_f_sha256.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pbkdf2_f_sha256.sv
// pbkdf2_f_sha256: iterating HMAC-SHA256 engine for the PBKDF2 block function F(P,S,c,i).
// Optional abort input is enabled with `define PBKDF2_ABORT_EN.
module sha256_1024in (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [1023:0] in_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [255:0]  out_o
);
    localparam logic [31:0] K [64] = '{
        'h428a2f98, 'h71374491, 'hb5c0fbcf, 'he9b5dba5, 'h3956c25b, 'h59f111f1, 'h923f82a4, 'hab1c5ed5,
        'hd807aa98, 'h12835b01, 'h243185be, 'h550c7dc3, 'h72be5d74, 'h80deb1fe, 'h9bdc06a7, 'hc19bf174,
        'he49b69c1, 'hefbe4786, 'h0fc19dc6, 'h240ca1cc, 'h2de92c6f, 'h4a7484aa, 'h5cb0a9dc, 'h76f988da,
        'h983e5152, 'ha831c66d, 'hb00327c8, 'hbf597fc7, 'hc6e00bf3, 'hd5a79147, 'h06ca6351, 'h14292967,
        'h27b70a85, 'h2e1b2138, 'h4d2c6dfc, 'h53380d13, 'h650a7354, 'h766a0abb, 'h81c2c92e, 'h92722c85,
        'ha2bfe8a1, 'ha81a664b, 'hc24b8b70, 'hc76c51a3, 'hd192e819, 'hd6990624, 'hf40e3585, 'h106aa070,
        'h19a4c116, 'h1e376c08, 'h2748774c, 'h34b0bcb5, 'h391c0cb3, 'h4ed8aa4a, 'h5b9cca4f, 'h682e6ff3,
        'h748f82ee, 'h78a5636f, 'h84c87814, 'h8cc70208, 'h90befffa, 'ha4506ceb, 'hbef9a3f7, 'hc67178f2};
    localparam logic [255:0] H0 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    typedef enum logic [1:0] {C_IDLE, C_RUN, C_OUT} cst_t;
    cst_t         cst_q, cst_d;
    logic [511:0] w_q, w_d, m2_q, m2_d;
    logic [255:0] s_q, s_d, hv_q, hv_d, s_nx, sum;
    logic [5:0]   rnd_q, rnd_d;
    logic         blk_q, blk_d;
    logic [31:0]  a, b, c, d, e, f, g, h, t1, t2, wn;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        return r;
    endfunction

    // w_q is a sliding 16-word schedule window; the oldest word sits at the top
    assign {a, b, c, d, e, f, g, h} = s_q;
    assign t1   = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + K[rnd_q] + w_q[511:480];
    assign t2   = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    assign s_nx = {t1 + t2, a, b, c, d + t1, e, f, g};
    assign sum  = add8(hv_q, s_nx);
    assign wn   = (rr(w_q[63:32], 17) ^ rr(w_q[63:32], 19) ^ (w_q[63:32] >> 10)) + w_q[223:192]
                + (rr(w_q[479:448], 7) ^ rr(w_q[479:448], 18) ^ (w_q[479:448] >> 3)) + w_q[511:480];
    assign in_ready_o  = cst_q == C_IDLE;
    assign out_valid_o = cst_q == C_OUT;
    assign out_o       = hv_q;

    always_comb begin
        cst_d = cst_q;
        w_d   = w_q;
        m2_d  = m2_q;
        s_d   = s_q;
        hv_d  = hv_q;
        rnd_d = rnd_q;
        blk_d = blk_q;
        case (cst_q)
            C_IDLE: if (in_valid_i) begin
                w_d   = in_i[1023:512];
                m2_d  = in_i[511:0];
                s_d   = H0;
                hv_d  = H0;
                rnd_d = '0;
                blk_d = 1'b0;
                cst_d = C_RUN;
            end
            C_RUN: begin
                s_d   = s_nx;
                w_d   = {w_q[479:0], wn};
                rnd_d = rnd_q + 6'd1;
                if (&rnd_q) begin
                    hv_d  = sum;
                    s_d   = sum;
                    w_d   = m2_q;
                    blk_d = 1'b1;
                    cst_d = blk_q ? C_OUT : C_RUN;
                end
            end
            C_OUT: if (out_ready_i) cst_d = C_IDLE;
            default: cst_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cst_q <= C_IDLE;
            w_q   <= '0;
            m2_q  <= '0;
            s_q   <= '0;
            hv_q  <= '0;
            rnd_q <= '0;
            blk_q <= 1'b0;
        end else begin
            cst_q <= cst_d;
            w_q   <= w_d;
            m2_q  <= m2_d;
            s_q   <= s_d;
            hv_q  <= hv_d;
            rnd_q <= rnd_d;
            blk_q <= blk_d;
        end
    end
endmodule

module pbkdf2_f_sha256 #(
    parameter int ITER_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [511:0]      key_i,
    input  logic [407:0]      salt_i,
    input  logic [5:0]        salt_len_i,
    input  logic [31:0]       blk_idx_i,
    input  logic [ITER_W-1:0] iter_i,
    input  logic              v_i,
    output logic              r_o,
    output logic [255:0]      dk_o,
    output logic              err_o,
    output logic [ITER_W-1:0] iter_cnt_o,
    output logic              v_o,
    input  logic              r_i
`ifdef PBKDF2_ABORT_EN
    ,
    input  logic              abort_i
`endif
);
    localparam logic [255:0] PAD = {8'h80, 184'b0, 64'd768};
    typedef enum logic [2:0] {IDLE, IN_LOAD, IN_WAIT, OUT_LOAD, OUT_WAIT, ACCUM, DONE} state_t;
    state_t            st_q, st_d;
    logic [511:0]      key_q, key_d, blk1;
    logic [407:0]      salt_q, salt_d;
    logic [5:0]        len_q, len_d;
    logic [31:0]       idx_q, idx_d;
    logic [ITER_W-1:0] rem_q, rem_d, cnt_q, cnt_d;
    logic [255:0]      acc_q, acc_d, t_q, t_d, dk_q, dk_d, c_out;
    logic              err_q, err_d, ab_q, ab_d, abort;
    logic              c_iv, c_ir, c_ov, c_or;
    logic [1023:0]     c_in;

`ifdef PBKDF2_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    // first-iteration message: masked salt, then INT32_BE(i) and 0x80 shifted in right after it
    assign blk1 = {salt_q & ~({408{1'b1}} >> {len_q, 3'b0}), 104'b0}
                | ({idx_q, 8'h80, 472'b0} >> {len_q, 3'b0})
                | {448'b0, 64'd544 + 64'({len_q, 3'b0})};
    // t_q holds the inner hash during the outer pass and U otherwise
    assign c_in = {key_q ^ {64{st_q == OUT_LOAD ? 8'h5c : 8'h36}},
                   (st_q == IN_LOAD && cnt_q == '0) ? blk1 : {t_q, PAD}};
    assign c_iv = st_q == IN_LOAD || st_q == OUT_LOAD;
    assign c_or = (st_q == IN_WAIT || st_q == OUT_WAIT) && c_ov;
    assign r_o        = st_q == IDLE;
    assign v_o        = st_q == DONE;
    assign dk_o       = dk_q;
    assign err_o      = err_q;
    assign iter_cnt_o = cnt_q;

    always_comb begin
        st_d   = st_q;
        key_d  = key_q;
        salt_d = salt_q;
        len_d  = len_q;
        idx_d  = idx_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        t_d    = t_q;
        dk_d   = dk_q;
        err_d  = err_q;
        ab_d   = ab_q;
        case (st_q)
            IDLE: if (v_i) begin
                key_d  = key_i;
                salt_d = salt_i;
                len_d  = salt_len_i;
                idx_d  = blk_idx_i;
                rem_d  = iter_i == '0 ? ITER_W'(1) : iter_i;
                cnt_d  = '0;
                acc_d  = '0;
                dk_d   = '0;
                ab_d   = 1'b0;
                err_d  = salt_len_i > 6'd51;
                st_d   = err_d ? DONE : IN_LOAD;
            end
            IN_LOAD, OUT_LOAD: if (c_ir) begin
                st_d = st_q == IN_LOAD ? IN_WAIT : OUT_WAIT;
                ab_d = abort;
            end else if (abort) begin
                st_d  = IDLE;
                acc_d = '0;
                cnt_d = '0;
            end
            IN_WAIT, OUT_WAIT: if (c_ov) begin
                t_d  = c_out;
                st_d = st_q == IN_WAIT ? OUT_LOAD : ACCUM;
                if (abort || ab_q) begin
                    st_d  = IDLE;
                    acc_d = '0;
                    cnt_d = '0;
                    ab_d  = 1'b0;
                end
            end else if (abort) ab_d = 1'b1;
            ACCUM: begin
                acc_d = acc_q ^ t_q;
                cnt_d = &cnt_q ? cnt_q : cnt_q + ITER_W'(1);
                rem_d = rem_q - ITER_W'(1);
                dk_d  = rem_q == ITER_W'(1) ? acc_d : dk_q;
                st_d  = rem_q == ITER_W'(1) ? DONE : IN_LOAD;
            end
            DONE: if (r_i) st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q   <= IDLE;
            key_q  <= '0;
            salt_q <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
            t_q    <= '0;
            dk_q   <= '0;
            err_q  <= 1'b0;
            ab_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            key_q  <= key_d;
            salt_q <= salt_d;
            len_q  <= len_d;
            idx_q  <= idx_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            t_q    <= t_d;
            dk_q   <= dk_d;
            err_q  <= err_d;
            ab_q   <= ab_d;
        end
    end

    sha256_1024in u_core (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (c_iv),
        .in_ready_o  (c_ir),
        .in_i        (c_in),
        .out_valid_o (c_ov),
        .out_ready_i (c_or),
        .out_o       (c_out)
    );
endmodule

// File: tb/tb_pbkdf2_f_sha256.sv
// tb_pbkdf2_f_sha256: randomized self-checking bench against a byte-level PBKDF2/HMAC/SHA-256 model.
module tb_pbkdf2_f_sha256;
    localparam logic [31:0] KT [64] = '{
        'h428a2f98, 'h71374491, 'hb5c0fbcf, 'he9b5dba5, 'h3956c25b, 'h59f111f1, 'h923f82a4, 'hab1c5ed5,
        'hd807aa98, 'h12835b01, 'h243185be, 'h550c7dc3, 'h72be5d74, 'h80deb1fe, 'h9bdc06a7, 'hc19bf174,
        'he49b69c1, 'hefbe4786, 'h0fc19dc6, 'h240ca1cc, 'h2de92c6f, 'h4a7484aa, 'h5cb0a9dc, 'h76f988da,
        'h983e5152, 'ha831c66d, 'hb00327c8, 'hbf597fc7, 'hc6e00bf3, 'hd5a79147, 'h06ca6351, 'h14292967,
        'h27b70a85, 'h2e1b2138, 'h4d2c6dfc, 'h53380d13, 'h650a7354, 'h766a0abb, 'h81c2c92e, 'h92722c85,
        'ha2bfe8a1, 'ha81a664b, 'hc24b8b70, 'hc76c51a3, 'hd192e819, 'hd6990624, 'hf40e3585, 'h106aa070,
        'h19a4c116, 'h1e376c08, 'h2748774c, 'h34b0bcb5, 'h391c0cb3, 'h4ed8aa4a, 'h5b9cca4f, 'h682e6ff3,
        'h748f82ee, 'h78a5636f, 'h84c87814, 'h8cc70208, 'h90befffa, 'ha4506ceb, 'hbef9a3f7, 'hc67178f2};
    localparam logic [255:0] H0  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DK1 = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
    localparam logic [255:0] DK2 = 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;

    logic         clk = 1'b0, rst = 1'b1, vi = 1'b0, ri = 1'b0;
    logic [511:0] key = '0;
    logic [407:0] salt = '0;
    logic [5:0]   slen = '0;
    logic [31:0]  bidx = '0;
    logic [15:0]  iter = '0;
    logic         ro, err, vo;
    logic [255:0] dk;
    logic [15:0]  icnt;
`ifdef PBKDF2_ABORT_EN
    logic         abort = 1'b0;
`endif
    int           vec = 0, bad = 0, niv = 0, nor_ = 0, nvo = 0;
    logic [7:0]   mb [128];
    int           ml;

    pbkdf2_f_sha256 dut (
        .clk_i(clk), .rst_i(rst), .key_i(key), .salt_i(salt), .salt_len_i(slen),
        .blk_idx_i(bidx), .iter_i(iter), .v_i(vi), .r_o(ro), .dk_o(dk), .err_o(err),
        .iter_cnt_o(icnt), .v_o(vo), .r_i(ri)
`ifdef PBKDF2_ABORT_EN
        , .abort_i(abort)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dut.c_iv) niv <= niv + 1;
        if (dut.c_ov && dut.c_or) nor_ <= nor_ + 1;
        if (vo) nvo <= nvo + 1;
    end

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int j = 0; j < 8; j++) v[j] = hin[255-32*j -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int j = 0; j < 8; j++) r[255-32*j -: 32] = hin[255-32*j -: 32] + v[j];
        return r;
    endfunction

    // SHA-256 of the ml bytes in mb, with standard padding
    task automatic sha_mb(output logic [255:0] dg);
        logic [511:0] blk;
        logic [63:0]  bl;
        logic [7:0]   by;
        int nb, x;
        dg = H0;
        nb = (ml + 9 + 63) / 64;
        bl = 64'(ml) * 64'd8;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < 64; k++) begin
                x = b * 64 + k;
                if (x < ml) by = mb[x];
                else if (x == ml) by = 8'h80;
                else if (x >= nb * 64 - 8) by = bl[8*(nb*64-1-x) +: 8];
                else by = 8'h00;
                blk[511-8*k -: 8] = by;
            end
            dg = compress(dg, blk);
        end
    endtask

    task automatic hmac(input logic [511:0] k, input logic [439:0] m, input int l, output logic [255:0] dg);
        logic [255:0] ih;
        for (int j = 0; j < 64; j++) mb[j] = k[511-8*j -: 8] ^ 8'h36;
        for (int j = 0; j < l; j++) mb[64+j] = m[439-8*j -: 8];
        ml = 64 + l;
        sha_mb(ih);
        for (int j = 0; j < 64; j++) mb[j] = k[511-8*j -: 8] ^ 8'h5c;
        for (int j = 0; j < 32; j++) mb[64+j] = ih[255-8*j -: 8];
        ml = 96;
        sha_mb(dg);
    endtask

    task automatic f_model(input logic [511:0] k, input logic [407:0] s, input int l, input logic [31:0] ix,
                           input logic [15:0] c, output logic [255:0] t);
        logic [439:0] m;
        logic [255:0] u;
        m = '0;
        for (int j = 0; j < l; j++) m[439-8*j -: 8] = s[407-8*j -: 8];
        m[439-8*l -: 32] = ix;
        hmac(k, m, l + 4, u);
        t = u;
        for (int j = 1; j < (c == 0 ? 1 : int'(c)); j++) begin
            m = {u, 184'b0};
            hmac(k, m, 32, u);
            t = t ^ u;
        end
    endtask

    task automatic rnd_inputs(output logic [511:0] k, output logic [407:0] s, output logic [5:0] l, output logic [31:0] ix);
        int kl;
        kl = $urandom_range(0, 64);
        for (int j = 0; j < 64; j++) k[511-8*j -: 8] = j < kl ? 8'($urandom) : 8'h00;
        for (int j = 0; j < 51; j++) s[407-8*j -: 8] = 8'($urandom);
        l  = 6'($urandom_range(0, 51));
        ix = $urandom;
    endtask

    task automatic start_job(input logic [511:0] k, input logic [407:0] s, input logic [5:0] l,
                             input logic [31:0] ix, input logic [15:0] c);
        int n = 0;
        while (ro !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        vec++;
        if (ro !== 1'b1) begin bad++; $display("FAIL start_ready: r_o=%b required 1", ro); end
        key = k; salt = s; slen = l; bidx = ix; iter = c; vi = 1'b1;
        @(negedge clk);
        vi = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int cyc);
        cyc = 0;
        while (vo !== 1'b1 && cyc < lim) begin @(negedge clk); cyc++; end
        vec++;
        if (vo !== 1'b1) begin bad++; $display("FAIL done_timeout: v_o=%b after %0d cycles required 1", vo, cyc); end
    endtask

    task automatic finish_job;
        ri = 1'b1;
        @(negedge clk);
        ri = 1'b0;
    endtask

    task automatic run_job(input logic [511:0] k, input logic [407:0] s, input logic [5:0] l, input logic [31:0] ix,
                           input logic [15:0] c, output logic [255:0] d, output logic e, output logic [15:0] n, output int cyc);
        start_job(k, s, l, ix, c);
        wait_done(300 * (c == 0 ? 1 : int'(c)) + 50, cyc);
        d = dk; e = err; n = icnt;
        finish_job();
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vec++; if (ro !== 1'b1) begin bad++; $display("FAIL reset_r_o: got %b want 1", ro); end
        vec++; if (vo !== 1'b0) begin bad++; $display("FAIL reset_v_o: got %b want 0", vo); end
        vec++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err_o: got %b want 0", err); end
        vec++; if (dk !== '0) begin bad++; $display("FAIL reset_dk_o: got %h want 0", dk); end
        vec++; if (icnt !== '0) begin bad++; $display("FAIL reset_iter_cnt: got %0d want 0", icnt); end
        rst = 1'b0;
        @(negedge clk);
        vec++; if (ro !== 1'b1 || vo !== 1'b0) begin bad++; $display("FAIL reset_release: r_o=%b v_o=%b want 1 0", ro, vo); end
    endtask

    task automatic test_known;
        logic [511:0] k;
        logic [407:0] s;
        logic [255:0] d;
        logic e;
        logic [15:0] n;
        int cyc;
        k = {64'h70617373776f7264, 448'b0};
        s = {32'h73616c74, 376'b0};
        run_job(k, s, 6'd4, 32'd1, 16'd1, d, e, n, cyc);
        vec++; if (d !== DK1) begin bad++; $display("FAIL known_c1_dk: got %h want %h", d, DK1); end
        vec++; if (e !== 1'b0) begin bad++; $display("FAIL known_c1_err: got %b want 0", e); end
        vec++; if (n !== 16'd1) begin bad++; $display("FAIL known_c1_cnt: got %0d want 1", n); end
        run_job(k, s, 6'd4, 32'd1, 16'd2, d, e, n, cyc);
        vec++; if (d !== DK2) begin bad++; $display("FAIL known_c2_dk: got %h want %h", d, DK2); end
        vec++; if (n !== 16'd2) begin bad++; $display("FAIL known_c2_cnt: got %0d want 2", n); end
        run_job(k, s, 6'd4, 32'd1, 16'd0, d, e, n, cyc);
        vec++; if (d !== DK1) begin bad++; $display("FAIL known_c0_dk: got %h want %h", d, DK1); end
        vec++; if (n !== 16'd1) begin bad++; $display("FAIL known_c0_cnt: got %0d want 1", n); end
    endtask

    task automatic test_salt_len;
        logic [511:0] k;
        logic [407:0] s;
        logic [5:0] l;
        logic [31:0] ix;
        logic [255:0] d, x;
        logic e;
        logic [15:0] n;
        int cyc, b0;
        rnd_inputs(k, s, l, ix);
        b0 = niv;
        run_job(k, s, 6'd52, ix, 16'd3, d, e, n, cyc);
        vec++; if (cyc !== 0) begin bad++; $display("FAIL len52_latency: got %0d extra cycles want 0", cyc); end
        vec++; if (e !== 1'b1) begin bad++; $display("FAIL len52_err: got %b want 1", e); end
        vec++; if (d !== '0) begin bad++; $display("FAIL len52_dk: got %h want 0", d); end
        vec++; if (n !== 16'd0) begin bad++; $display("FAIL len52_cnt: got %0d want 0", n); end
        vec++; if (niv - b0 !== 0) begin bad++; $display("FAIL len52_no_hash: got %0d in_valid cycles want 0", niv - b0); end
        f_model(k, s, 51, ix, 16'd2, x);
        run_job(k, s, 6'd51, ix, 16'd2, d, e, n, cyc);
        vec++; if (d !== x) begin bad++; $display("FAIL len51_dk: got %h want %h", d, x); end
        vec++; if (e !== 1'b0) begin bad++; $display("FAIL len51_err: got %b want 0", e); end
    endtask

    task automatic test_random;
        logic [511:0] k;
        logic [407:0] s;
        logic [5:0] l;
        logic [31:0] ix;
        logic [15:0] c, n;
        logic [255:0] d, x;
        logic e;
        int cyc;
        for (int r = 0; r < 6; r++) begin
            rnd_inputs(k, s, l, ix);
            c = 16'($urandom_range(0, 3));
            f_model(k, s, int'(l), ix, c, x);
            run_job(k, s, l, ix, c, d, e, n, cyc);
            vec++; if (d !== x) begin bad++; $display("FAIL rand_dk[%0d] len=%0d c=%0d: got %h want %h", r, l, c, d, x); end
            vec++; if (n !== 16'(c == 0 ? 1 : c)) begin bad++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", r, n, c == 0 ? 1 : c); end
            vec++; if (e !== 1'b0) begin bad++; $display("FAIL rand_err[%0d]: got %b want 0", r, e); end
        end
    endtask

    task automatic test_backpressure;
        logic [511:0] k;
        logic [407:0] s;
        logic [5:0] l;
        logic [31:0] ix;
        logic [255:0] d0, x;
        logic [15:0] c0;
        int cyc, b0;
        rnd_inputs(k, s, l, ix);
        f_model(k, s, int'(l), ix, 16'd1, x);
        start_job(k, s, l, ix, 16'd1);
        wait_done(400, cyc);
        d0 = dk; c0 = icnt; b0 = niv;
        vec++; if (d0 !== x) begin bad++; $display("FAIL hold_dk_model: got %h want %h", d0, x); end
        for (int i = 0; i < 20; i++) begin
            vi = (i == 5);
            @(negedge clk);
            vec++;
            if (vo !== 1'b1 || dk !== d0 || icnt !== c0 || ro !== 1'b0) begin
                bad++;
                $display("FAIL hold[%0d]: v_o=%b r_o=%b cnt=%0d dk=%h want 1 0 %0d %h", i, vo, ro, icnt, dk, c0, d0);
            end
        end
        vi = 1'b0;
        finish_job();
        vec++; if (vo !== 1'b0 || ro !== 1'b1) begin bad++; $display("FAIL hold_release: v_o=%b r_o=%b want 0 1", vo, ro); end
        vec++; if (niv - b0 !== 0) begin bad++; $display("FAIL hold_v_i_ignored: got %0d in_valid cycles want 0", niv - b0); end
    endtask

    task automatic test_reset_mid;
        logic [511:0] k;
        logic [407:0] s;
        logic [5:0] l;
        logic [31:0] ix;
        logic [255:0] d, x;
        logic e;
        logic [15:0] n;
        int cyc, b0;
        rnd_inputs(k, s, l, ix);
        start_job(k, s, l, ix, 16'd5);
        cyc = 0;
        while (icnt !== 16'd2 && cyc < 2000) begin @(negedge clk); cyc++; end
        b0 = niv;
        while (niv < b0 + 2 && cyc < 2500) begin @(negedge clk); cyc++; end
        vec++; if (niv < b0 + 2) begin bad++; $display("FAIL midrst_reach: in_valid cycles %0d want 2", niv - b0); end
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vec++;
        if (ro !== 1'b1 || vo !== 1'b0 || icnt !== '0 || dk !== '0 || err !== 1'b0) begin
            bad++;
            $display("FAIL midrst_outputs: r_o=%b v_o=%b cnt=%0d err=%b dk=%h want 1 0 0 0 0", ro, vo, icnt, err, dk);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rnd_inputs(k, s, l, ix);
        f_model(k, s, int'(l), ix, 16'd1, x);
        run_job(k, s, l, ix, 16'd1, d, e, n, cyc);
        vec++; if (d !== x) begin bad++; $display("FAIL midrst_next_dk: got %h want %h", d, x); end
        vec++; if (n !== 16'd1) begin bad++; $display("FAIL midrst_next_cnt: got %0d want 1", n); end
    endtask

`ifdef PBKDF2_ABORT_EN
    task automatic test_abort;
        logic [511:0] k;
        logic [407:0] s;
        logic [5:0] l;
        logic [31:0] ix;
        logic [255:0] d, x;
        logic e;
        logic [15:0] n;
        int cyc, b0, bo, bv;
        rnd_inputs(k, s, l, ix);
        b0 = niv;
        start_job(k, s, l, ix, 16'd2);
        cyc = 0;
        while (niv < b0 + 1 && cyc < 100) begin @(negedge clk); cyc++; end
        repeat (3) @(negedge clk);
        bo = nor_; bv = nvo;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        cyc = 0;
        while (ro !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
        vec++; if (ro !== 1'b1) begin bad++; $display("FAIL abort_idle: r_o=%b want 1", ro); end
        vec++; if (nor_ - bo !== 1) begin bad++; $display("FAIL abort_drain: got %0d out_ready pulses want 1", nor_ - bo); end
        vec++; if (nvo - bv !== 0 || vo !== 1'b0) begin bad++; $display("FAIL abort_no_v_o: got %0d v_o cycles want 0", nvo - bv); end
        vec++; if (icnt !== '0) begin bad++; $display("FAIL abort_cnt: got %0d want 0", icnt); end
        rnd_inputs(k, s, l, ix);
        f_model(k, s, int'(l), ix, 16'd1, x);
        run_job(k, s, l, ix, 16'd1, d, e, n, cyc);
        vec++; if (d !== x) begin bad++; $display("FAIL abort_next_dk: got %h want %h", d, x); end
    endtask
`endif

    initial begin
        test_reset();
        test_known();
        test_salt_len();
        test_random();
        test_backpressure();
        test_reset_mid();
`ifdef PBKDF2_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
